// File: rtl/cyt_rdma_rx_deadlock_detector.sv
// rtl/cyt_rdma_rx_deadlock_detector.sv - sequential deadlock detector for the rx HLS pipeline
module cyt_rdma_rx_deadlock_detector #(
    parameter int                N_AXIS    = 12,
    parameter int                N_INST    = 10,
    parameter logic [N_AXIS-1:0] AXIS_MASK = 12'h030,
    parameter int                THRESHOLD = 1024,
    parameter int                CNT_W     = 16,
    parameter int                CH_W      = $clog2(N_AXIS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_AXIS-1:0] axis_block_sigs,
    input  logic [N_INST-1:0] inst_idle_sigs,
    input  logic              clear,
    output logic              block,
    output logic              deadlock,
    output logic [CH_W-1:0]   deadlock_chan,
    output logic [CNT_W-1:0]  block_cycles,
    output logic [7:0]        deadlock_events
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WATCH    = 2'd1,
        DEADLOCK = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] THRESH  = CNT_W'(THRESHOLD);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state;
    state_t            state_d;
    logic [N_AXIS-1:0] masked;
    logic              cond;
    logic [CH_W-1:0]   low_idx;
    logic [CNT_W-1:0]  cnt_inc;
    logic              enter_deadlock;

    assign masked  = axis_block_sigs & AXIS_MASK;
    assign cond    = (|masked) & ~(&inst_idle_sigs);
    assign cnt_inc = block_cycles + CNT_W'(1);

    // Descending scan so the lowest set index is the one left standing.
    always_comb begin
        low_idx = '0;
        for (int i = N_AXIS - 1; i >= 0; i--) begin
            if (masked[i]) begin
                low_idx = CH_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (cond) begin
                        state_d = (THRESHOLD == 1) ? DEADLOCK : WATCH;
                    end
                end
                WATCH: begin
                    if (!cond) begin
                        state_d = IDLE;
                    end else if (cnt_inc == THRESH) begin
                        state_d = DEADLOCK;
                    end
                end
                DEADLOCK: state_d = DEADLOCK;
                default:  state_d = IDLE;
            endcase
        end
    end

    assign enter_deadlock = (state != DEADLOCK) && (state_d == DEADLOCK);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            block           <= 1'b0;
            deadlock        <= 1'b0;
            deadlock_chan   <= '0;
            block_cycles    <= '0;
            deadlock_events <= '0;
        end else begin
            block <= cond;
            if (clear) begin
                // Clear wins over a same-cycle blockage; the next episode starts one edge later.
                deadlock      <= 1'b0;
                block_cycles  <= '0;
                deadlock_chan <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (cond) begin
                            block_cycles  <= CNT_W'(1);
                            deadlock_chan <= low_idx;
                        end
                    end
                    WATCH: begin
                        if (cond) begin
                            block_cycles <= cnt_inc;
                        end else begin
                            block_cycles <= '0;
                        end
                    end
                    DEADLOCK: begin
                        if (cond && (block_cycles != CNT_MAX)) begin
                            block_cycles <= cnt_inc;
                        end
                    end
                    default: begin
                        block_cycles <= '0;
                    end
                endcase
                if (enter_deadlock) begin
                    deadlock <= 1'b1;
                    if (deadlock_events != 8'hFF) begin
                        deadlock_events <= deadlock_events + 8'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cyt_rdma_rx_deadlock_detector.sv
// tb/tb_cyt_rdma_rx_deadlock_detector.sv - directed self-checking bench for the rx deadlock detector
module tb_cyt_rdma_rx_deadlock_detector;

    logic        clock;
    logic        reset;
    logic [11:0] axis_block_sigs;
    logic [9:0]  inst_idle_sigs;
    logic        clear;

    logic        a_block, a_deadlock;
    logic [3:0]  a_chan;
    logic [15:0] a_cycles;
    logic [7:0]  a_events;

    logic        b_block, b_deadlock;
    logic [3:0]  b_chan;
    logic [3:0]  b_cycles;
    logic [7:0]  b_events;

    int tests;
    int fails;

    cyt_rdma_rx_deadlock_detector #(
        .N_AXIS(12), .N_INST(10), .AXIS_MASK(12'h030), .THRESHOLD(4), .CNT_W(16), .CH_W(4)
    ) dut_a (
        .clock(clock), .reset(reset), .axis_block_sigs(axis_block_sigs),
        .inst_idle_sigs(inst_idle_sigs), .clear(clear), .block(a_block),
        .deadlock(a_deadlock), .deadlock_chan(a_chan), .block_cycles(a_cycles),
        .deadlock_events(a_events)
    );

    cyt_rdma_rx_deadlock_detector #(
        .N_AXIS(12), .N_INST(10), .AXIS_MASK(12'h030), .THRESHOLD(1), .CNT_W(4), .CH_W(4)
    ) dut_b (
        .clock(clock), .reset(reset), .axis_block_sigs(axis_block_sigs),
        .inst_idle_sigs(inst_idle_sigs), .clear(clear), .block(b_block),
        .deadlock(b_deadlock), .deadlock_chan(b_chan), .block_cycles(b_cycles),
        .deadlock_events(b_events)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; clear = 1'b0; axis_block_sigs = 12'h030; inst_idle_sigs = 10'h000;
        tick(); tick();
        tests++; if (a_block !== 1'b0) begin fails++; $display("FAIL reset_block: got %0h expected 0", a_block); end
        tests++; if (a_deadlock !== 1'b0) begin fails++; $display("FAIL reset_deadlock: got %0h expected 0", a_deadlock); end
        tests++; if (a_chan !== 4'd0) begin fails++; $display("FAIL reset_chan: got %0d expected 0", a_chan); end
        tests++; if (a_cycles !== 16'd0) begin fails++; $display("FAIL reset_cycles: got %0d expected 0", a_cycles); end
        tests++; if (a_events !== 8'd0) begin fails++; $display("FAIL reset_events: got %0d expected 0", a_events); end
        axis_block_sigs = 12'h000; reset = 1'b0;
        tick();
        tests++; if (a_cycles !== 16'd0 || a_block !== 1'b0) begin fails++; $display("FAIL idle_quiet: cycles %0d block %0h expected 0 0", a_cycles, a_block); end
    endtask

    task automatic test_basic();
        axis_block_sigs = 12'h020; inst_idle_sigs = 10'h000;
        tick();
        tests++; if (a_block !== 1'b1) begin fails++; $display("FAIL basic_block_latency: got %0h expected 1", a_block); end
        tests++; if (a_cycles !== 16'd1) begin fails++; $display("FAIL basic_cycles1: got %0d expected 1", a_cycles); end
        tick(); tick();
        tests++; if (a_deadlock !== 1'b0) begin fails++; $display("FAIL basic_early_deadlock: got %0h expected 0", a_deadlock); end
        tick();
        tests++; if (a_deadlock !== 1'b1) begin fails++; $display("FAIL basic_deadlock: got %0h expected 1", a_deadlock); end
        tests++; if (a_chan !== 4'd5) begin fails++; $display("FAIL basic_chan: got %0d expected 5", a_chan); end
        tests++; if (a_cycles !== 16'd4) begin fails++; $display("FAIL basic_cycles4: got %0d expected 4", a_cycles); end
        tests++; if (a_events !== 8'd1) begin fails++; $display("FAIL basic_events: got %0d expected 1", a_events); end
        axis_block_sigs = 12'h000; tick(); tick();
        tests++; if (a_deadlock !== 1'b1 || a_cycles !== 16'd4) begin fails++; $display("FAIL basic_sticky: deadlock %0h cycles %0d expected 1 4", a_deadlock, a_cycles); end
        clear = 1'b1; tick(); clear = 1'b0;
    endtask

    task automatic test_restart();
        axis_block_sigs = 12'h010;
        tick(); tick(); tick();
        tests++; if (a_cycles !== 16'd3 || a_deadlock !== 1'b0) begin fails++; $display("FAIL restart_burst1: cycles %0d deadlock %0h expected 3 0", a_cycles, a_deadlock); end
        axis_block_sigs = 12'h000;
        tick();
        tests++; if (a_cycles !== 16'd0 || a_block !== 1'b0 || a_deadlock !== 1'b0) begin fails++; $display("FAIL restart_gap: cycles %0d block %0h deadlock %0h expected 0 0 0", a_cycles, a_block, a_deadlock); end
        axis_block_sigs = 12'h010;
        tick(); tick(); tick();
        tests++; if (a_deadlock !== 1'b0 || a_cycles !== 16'd3) begin fails++; $display("FAIL restart_burst2_early: deadlock %0h cycles %0d expected 0 3", a_deadlock, a_cycles); end
        tick();
        tests++; if (a_deadlock !== 1'b1 || a_events !== 8'd2 || a_chan !== 4'd4) begin fails++; $display("FAIL restart_deadlock: deadlock %0h events %0d chan %0d expected 1 2 4", a_deadlock, a_events, a_chan); end
        axis_block_sigs = 12'h000; clear = 1'b1; tick(); clear = 1'b0;
    endtask

    task automatic test_masking();
        int bad;
        bad = 0;
        axis_block_sigs = 12'h00C; inst_idle_sigs = 10'h000;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (a_block !== 1'b0 || a_deadlock !== 1'b0 || a_cycles !== 16'd0) bad++;
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL mask_unmasked: %0d bad cycles expected 0", bad); end
        bad = 0;
        axis_block_sigs = 12'h030; inst_idle_sigs = 10'h3FF;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (a_block !== 1'b0 || a_deadlock !== 1'b0 || a_cycles !== 16'd0) bad++;
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL mask_all_idle: %0d bad cycles expected 0", bad); end
        inst_idle_sigs = 10'h3FE;
        tick();
        tests++; if (a_block !== 1'b1 || a_cycles !== 16'd1) begin fails++; $display("FAIL mask_partial_idle: block %0h cycles %0d expected 1 1", a_block, a_cycles); end
        axis_block_sigs = 12'h000; inst_idle_sigs = 10'h000; tick();
    endtask

    task automatic test_clear();
        axis_block_sigs = 12'h020;
        tick(); tick(); tick(); tick();
        tests++; if (a_deadlock !== 1'b1 || a_events !== 8'd3) begin fails++; $display("FAIL clear_pre: deadlock %0h events %0d expected 1 3", a_deadlock, a_events); end
        axis_block_sigs = 12'h030; clear = 1'b1;
        tick();
        clear = 1'b0;
        tests++; if (a_deadlock !== 1'b0 || a_cycles !== 16'd0 || a_chan !== 4'd0) begin fails++; $display("FAIL clear_edge: deadlock %0h cycles %0d chan %0d expected 0 0 0", a_deadlock, a_cycles, a_chan); end
        tests++; if (a_events !== 8'd3) begin fails++; $display("FAIL clear_events_kept: got %0d expected 3", a_events); end
        tick();
        tests++; if (a_cycles !== 16'd1 || a_chan !== 4'd4) begin fails++; $display("FAIL clear_next: cycles %0d chan %0d expected 1 4", a_cycles, a_chan); end
        axis_block_sigs = 12'h020;
        tick(); tick();
        tests++; if (a_deadlock !== 1'b0 || a_chan !== 4'd4) begin fails++; $display("FAIL clear_chan_hold: deadlock %0h chan %0d expected 0 4", a_deadlock, a_chan); end
        tick();
        tests++; if (a_deadlock !== 1'b1 || a_events !== 8'd4) begin fails++; $display("FAIL clear_second: deadlock %0h events %0d expected 1 4", a_deadlock, a_events); end
    endtask

    task automatic test_reset_mid();
        axis_block_sigs = 12'h000; clear = 1'b1; tick(); clear = 1'b0;
        axis_block_sigs = 12'h020;
        tick(); tick();
        tests++; if (a_cycles !== 16'd2) begin fails++; $display("FAIL rst_watch_pre: cycles %0d expected 2", a_cycles); end
        reset = 1'b1; clear = 1'b1;
        tick();
        reset = 1'b0; clear = 1'b0;
        tests++; if (a_block !== 1'b0 || a_deadlock !== 1'b0 || a_cycles !== 16'd0 || a_chan !== 4'd0 || a_events !== 8'd0) begin fails++; $display("FAIL rst_watch: block %0h dl %0h cyc %0d chan %0d ev %0d expected all 0", a_block, a_deadlock, a_cycles, a_chan, a_events); end
        tick();
        tests++; if (a_cycles !== 16'd1 || a_chan !== 4'd5) begin fails++; $display("FAIL rst_watch_idle: cycles %0d chan %0d expected 1 5", a_cycles, a_chan); end
        tick(); tick(); tick();
        tests++; if (a_deadlock !== 1'b1 || a_events !== 8'd1) begin fails++; $display("FAIL rst_dl_pre: deadlock %0h events %0d expected 1 1", a_deadlock, a_events); end
        reset = 1'b1;
        tick();
        reset = 1'b0; axis_block_sigs = 12'h000;
        tests++; if (a_block !== 1'b0 || a_deadlock !== 1'b0 || a_cycles !== 16'd0 || a_chan !== 4'd0 || a_events !== 8'd0) begin fails++; $display("FAIL rst_deadlock: block %0h dl %0h cyc %0d chan %0d ev %0d expected all 0", a_block, a_deadlock, a_cycles, a_chan, a_events); end
        tick();
        tests++; if (a_deadlock !== 1'b0 || a_cycles !== 16'd0) begin fails++; $display("FAIL rst_dl_idle: deadlock %0h cycles %0d expected 0 0", a_deadlock, a_cycles); end
    endtask

    task automatic test_saturation();
        int bad;
        bad = 0;
        reset = 1'b1; axis_block_sigs = 12'h000; tick(); reset = 1'b0;
        axis_block_sigs = 12'h010;
        tick();
        tests++; if (b_deadlock !== 1'b1 || b_cycles !== 4'd1 || b_events !== 8'd1) begin fails++; $display("FAIL sat_first_edge: dl %0h cyc %0d ev %0d expected 1 1 1", b_deadlock, b_cycles, b_events); end
        for (int i = 0; i < 19; i++) tick();
        tests++; if (b_cycles !== 4'd15) begin fails++; $display("FAIL sat_cycles: got %0d expected 15", b_cycles); end
        for (int i = 0; i < 260; i++) begin
            clear = 1'b1; tick(); clear = 1'b0;
            if (b_deadlock !== 1'b0 || b_cycles !== 4'd0) bad++;
            tick();
            if (b_deadlock !== 1'b1) bad++;
            if (i == 253 && b_events !== 8'd255) bad++;
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL sat_clear_loop: %0d bad samples expected 0", bad); end
        tests++; if (b_events !== 8'd255) begin fails++; $display("FAIL sat_events: got %0d expected 255", b_events); end
    endtask

    initial begin
        tests = 0; fails = 0;
        clock = 1'b0; reset = 1'b1; clear = 1'b0;
        axis_block_sigs = 12'h000; inst_idle_sigs = 10'h000;
        test_reset();
        test_basic();
        test_restart();
        test_masking();
        test_clear();
        test_reset_mid();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cyt_rdma_rx_deadlock_detector.md
Name: cyt_rdma_rx_deadlock_detector

Overview:
Sequential deadlock detector for the cyt_rdma receive-side HLS pipeline, complementing the combinational per-instance tx block monitors.
- Samples the AXIS-stream blocking and instance-idle vectors of the rx pipeline.
- Qualifies a blockage only while the pipeline is not fully idle.
- Declares a sticky deadlock after the blockage persists for a programmable number of consecutive cycles.
- Records the first blocked channel, blockage duration and deadlock event count, for readout by the platform debug/status logic.

Parameters:
N_AXIS, 12, width of axis_block_sigs
N_INST, 10, width of inst_idle_sigs
AXIS_MASK, 12'h030, channels belonging to the rx path; unmasked bits ignored
THRESHOLD, 1024, consecutive qualified-block cycles before deadlock; legal range 1..2^CNT_W-1
CNT_W, 16, width of the duration counter
CH_W, $clog2(N_AXIS), width of the channel index

Ports:
clock  in  1  single clock
reset  in  1  synchronous, active-high reset
axis_block_sigs  in  N_AXIS  per-stream blocked flags from the rx pipeline
inst_idle_sigs  in  N_INST  per-instance idle flags
clear  in  1  single-cycle pulse; rearms the detector
block  out  1  registered qualified-block condition
deadlock  out  1  sticky deadlock flag
deadlock_chan  out  CH_W  lowest masked channel index blocked at start of current episode
block_cycles  out  CNT_W  consecutive qualified-block cycles, saturating at all-ones
deadlock_events  out  8  number of IDLE/WATCH->DEADLOCK transitions, saturating at 255

Behaviour:
- Qualified condition: cond = |(axis_block_sigs & AXIS_MASK) & ~(&inst_idle_sigs). All inputs are sampled on the rising clock edge. No input registering.
- block <= cond every cycle. Latency is 1 cycle. It is independent of the FSM and is forced 0 by reset.
- Reset values: all outputs 0, FSM in IDLE.
- FSM states: IDLE, WATCH, DEADLOCK.
- IDLE, cond=1:
  - block_cycles <= 1.
  - deadlock_chan <= lowest set index of (axis_block_sigs & AXIS_MASK).
  - If THRESHOLD==1: go to DEADLOCK. Otherwise go to WATCH.
- IDLE, cond=0: stay in IDLE; block_cycles stays 0.
- WATCH, cond=1:
  - block_cycles <= block_cycles+1.
  - If block_cycles+1 == THRESHOLD: go to DEADLOCK.
- WATCH, cond=0: go to IDLE; block_cycles <= 0; deadlock_chan holds its value.
- Entry to DEADLOCK (from IDLE or WATCH):
  - deadlock <= 1 on the same edge.
  - deadlock_events increments, saturating at 255.
- DEADLOCK:
  - deadlock stays 1 regardless of cond.
  - block_cycles increments while cond=1, saturating at all-ones, and holds while cond=0.
  - deadlock_chan holds.
  - Exit is only via clear or reset.
- clear=1, any state:
  - Next state is IDLE.
  - deadlock, block_cycles and deadlock_chan <= 0.
  - deadlock_events is unaffected.
  - clear takes priority over cond and over threshold arrival in the same cycle. No new episode starts on the clear edge, even with cond=1; the episode starts on the next edge.
- Cycle count: with cond high on edges 1..THRESHOLD, deadlock is visible after edge THRESHOLD. A single cond=0 sample in WATCH restarts the count.
- Channel change mid-episode: deadlock_chan does not update.
- All instances idle forces cond=0, even when masked block bits are set.
- reset overrides clear.

Test Plan:
- THRESHOLD=4, AXIS_MASK=12'h030. Drive axis_block_sigs=12'h020, inst_idle=0 for 4 cycles -> block=1 one cycle after the first sample; deadlock=1 after the 4th edge; deadlock_chan=5; block_cycles=4; deadlock_events=1.
- Drive cond high for 3 cycles, low for 1, then high for 4 -> no deadlock after the first burst; block_cycles returns to 0; deadlock after the 4th cycle of the second burst.
- axis_block_sigs=12'h00C (unmasked) for 10 cycles; separately 12'h030 with inst_idle_sigs=10'h3FF -> block=0, deadlock=0, block_cycles=0 in both cases.
- In DEADLOCK, pulse clear while cond=1 -> deadlock=0, block_cycles=0, deadlock_chan=0 after that edge; block_cycles=1 on the next edge; second deadlock 4 cycles after clear; deadlock_events=2.
- Apply reset mid-WATCH (block_cycles=2), and separately in DEADLOCK -> all outputs 0, including deadlock_events; FSM in IDLE.
- THRESHOLD=1, CNT_W=4. Hold cond for 20 cycles -> deadlock after the first edge; block_cycles saturates at 15. Repeat clear/deadlock 260 times -> deadlock_events saturates at 255.
